// File: rtl/rbzero_pkg.sv
// ---------------------------------------------------------------------------
// rbzero_pkg
// Shared definitions for the rbzero view-state front end.
//   - view_state_t : states of the SPI frame receiver
//   - CMD_VIEW     : command byte that selects a view frame
//   - CMD_BITS / PAYLOAD_BITS : frame field lengths in bits
//   - RESET_*      : power-on player position, facing and viewplane (Q8.8)
//   - sat_inc      : saturating increment for the receiver bit counter
// ---------------------------------------------------------------------------
package rbzero_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_FULL    = 3'd3,
        ST_IGNORE  = 3'd4
    } view_state_t;

    localparam logic [7:0] CMD_VIEW     = 8'h00;
    localparam int         CMD_BITS     = 8;
    localparam int         PAYLOAD_BITS = 96;

    // Bit counter width; large enough for the payload, saturates at all-ones.
    localparam int         CNT_W        = 7;

    // Power-on view: standing at (1.5, 1.5), facing +x, viewplane -0.5 on y.
    localparam logic [15:0] RESET_PX = 16'h0180;
    localparam logic [15:0] RESET_PY = 16'h0180;
    localparam logic [15:0] RESET_FX = 16'h0100;
    localparam logic [15:0] RESET_FY = 16'h0000;
    localparam logic [15:0] RESET_VX = 16'h0000;
    localparam logic [15:0] RESET_VY = 16'hFF80;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Brings one asynchronous SPI pin into the clk domain and reports its edges.
// A two-flop synchroniser is followed by a history flop; rise/fall are the
// combinational compare of the synchronised level against the history flop.
//
// Ports:
//   clk    in  : system clock
//   rst_n  in  : asynchronous active-low reset
//   din    in  : raw pin, asynchronous to clk
//   level  out : synchronised pin level
//   rise   out : one-clk pulse on a synchronised 0->1 transition
//   fall   out : one-clk pulse on a synchronised 1->0 transition
//
// Parameter RST_VAL is the idle level of the pin, loaded into all three flops.
// ---------------------------------------------------------------------------
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic       meta_reg;
    logic       sync_reg;
    logic       hist_reg;
    logic [1:0] prime_reg;
    logic       primed;

    // Edges are suppressed until the real pin level has reached the history
    // flop. Otherwise a pin sitting at its non-idle level when reset releases
    // (e.g. ss_n held low mid-transaction) would be reported as a fresh edge.
    assign primed = (prime_reg == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg  <= RST_VAL;
            sync_reg  <= RST_VAL;
            hist_reg  <= RST_VAL;
            prime_reg <= 2'd0;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
            hist_reg <= sync_reg;
            if (!primed) begin
                prime_reg <= prime_reg + 2'd1;
            end
        end
    end

    assign level = sync_reg;
    assign rise  = primed &  sync_reg & ~hist_reg;
    assign fall  = primed & ~sync_reg &  hist_reg;

endmodule

// File: rtl/spi_view_loader.sv
// ---------------------------------------------------------------------------
// spi_view_loader
// Receives view frames over SPI (mode 0, MSB first) and presents them to the
// renderer as player position, facing vector and viewplane vector (Q8.8).
// A frame is one command byte followed by six W-bit words in the order
// px, py, fx, fy, vx, vy. Frames with a foreign command are drained silently;
// frames that end short or run long are dropped with an o_frame_err pulse.
//
// Build option SPI_VIEW_DOUBLE_BUFFER_EN:
//   defined   - a valid frame is staged in a pending set (o_pending=1) and
//               copied to the outputs on the next i_vblank_start.
//   undefined - a valid frame loads straight into the outputs when staged;
//               o_pending is tied low and i_vblank_start is ignored.
//
// Ports:
//   clk             in  : system (pixel) clock
//   rst_n           in  : asynchronous active-low reset
//   i_sclk          in  : SPI clock (async, mode 0, <= clk/6)
//   i_mosi          in  : SPI data, sampled on sclk rising
//   i_ss_n          in  : SPI select, active low, one frame per assertion
//   i_vblank_start  in  : one-clk pulse at start of vertical blank
//   o_px, o_py      out : player position
//   o_fx, o_fy      out : facing vector
//   o_vx, o_vy      out : viewplane vector
//   o_pending       out : validated frame waiting for vblank
//   o_frame_err     out : one-clk pulse when a malformed frame is dropped
// ---------------------------------------------------------------------------
module spi_view_loader #(
    parameter int         W        = 16,
    parameter logic [7:0] CMD_VIEW = 8'h00
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_sclk,
    input  logic         i_mosi,
    input  logic         i_ss_n,
    input  logic         i_vblank_start,
    output logic [W-1:0] o_px,
    output logic [W-1:0] o_py,
    output logic [W-1:0] o_fx,
    output logic [W-1:0] o_fy,
    output logic [W-1:0] o_vx,
    output logic [W-1:0] o_vy,
    output logic         o_pending,
    output logic         o_frame_err
);

    import rbzero_pkg::*;

    // Six-word view sets are kept packed with px in the top slot, which
    // matches the order the payload arrives in the shift register.
    localparam logic [5:0][W-1:0] RESET_SET = {
        W'(RESET_PX), W'(RESET_PY), W'(RESET_FX),
        W'(RESET_FY), W'(RESET_VX), W'(RESET_VY)
    };

    // Pin order in the synchroniser bank: bit0 sclk, bit1 mosi, bit2 ss_n.
    localparam logic [2:0] SYNC_RST = 3'b100;

    // -----------------------------------------------------------------------
    // Pin synchronisers
    // -----------------------------------------------------------------------
    logic [2:0] pin_vec;
    logic [2:0] pin_level;
    logic [2:0] pin_rise;
    logic [2:0] pin_fall;

    assign pin_vec = {i_ss_n, i_mosi, i_sclk};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            spi_sync_edge #(
                .RST_VAL (SYNC_RST[gi])
            ) u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .din   (pin_vec[gi]),
                .level (pin_level[gi]),
                .rise  (pin_rise[gi]),
                .fall  (pin_fall[gi])
            );
        end
    endgenerate

    logic sclk_rise;
    logic mosi_bit;
    logic ss_fall;
    logic ss_rise;

    // sclk activity only counts while the slave is selected.
    assign sclk_rise = pin_rise[0] & ~pin_level[2];
    assign mosi_bit  = pin_level[1];
    assign ss_fall   = pin_fall[2];
    assign ss_rise   = pin_rise[2];

    // -----------------------------------------------------------------------
    // Receiver state
    // -----------------------------------------------------------------------
    view_state_t             state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [PAYLOAD_BITS-1:0] shift_reg;
    logic [5:0][W-1:0]       out_reg;
    logic                    frame_err_reg;

    logic [PAYLOAD_BITS-1:0] shift_next;
    logic [7:0]              cmd_next;
    logic [5:0][W-1:0]       rx_view;

    assign shift_next = {shift_reg[PAYLOAD_BITS-2:0], mosi_bit};
    // The command byte as it will look once the current bit is shifted in.
    assign cmd_next   = shift_next[7:0];
    assign rx_view    = shift_reg[PAYLOAD_BITS-1 -: 6*W];

`ifdef SPI_VIEW_DOUBLE_BUFFER_EN
    logic [5:0][W-1:0] pend_reg;
    logic              pending_reg;
`else
    logic unused_vblank;
    assign unused_vblank = i_vblank_start;
`endif

    logic unused_pins;
    assign unused_pins = ^{pin_level[0], pin_rise[1], pin_fall[1], pin_fall[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            out_reg       <= RESET_SET;
            frame_err_reg <= 1'b0;
`ifdef SPI_VIEW_DOUBLE_BUFFER_EN
            pend_reg      <= RESET_SET;
            pending_reg   <= 1'b0;
`endif
        end else begin
            frame_err_reg <= 1'b0;

`ifdef SPI_VIEW_DOUBLE_BUFFER_EN
            // Commit the already-pending set. If a new frame is staged in
            // this same cycle, the staging below re-arms pending_reg and the
            // new frame waits for the following vblank.
            if (i_vblank_start && pending_reg) begin
                out_reg     <= pend_reg;
                pending_reg <= 1'b0;
            end
`endif

            if (ss_fall) begin
                // A fresh select always restarts framing, whatever state
                // the previous transaction was left in.
                state_reg <= ST_CMD;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                    end

                    ST_CMD: begin
                        if (ss_rise) begin
                            state_reg <= ST_IDLE;
                        end else if (sclk_rise) begin
                            shift_reg <= shift_next;
                            if (cnt_reg == CNT_W'(CMD_BITS - 1)) begin
                                cnt_reg   <= '0;
                                state_reg <= (cmd_next == CMD_VIEW) ? ST_PAYLOAD : ST_IGNORE;
                            end else begin
                                cnt_reg <= sat_inc(cnt_reg);
                            end
                        end
                    end

                    ST_PAYLOAD: begin
                        if (ss_rise) begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= ST_IDLE;
                        end else if (sclk_rise) begin
                            shift_reg <= shift_next;
                            cnt_reg   <= sat_inc(cnt_reg);
                            if (cnt_reg == CNT_W'(PAYLOAD_BITS - 1)) begin
                                state_reg <= ST_FULL;
                            end
                        end
                    end

                    ST_FULL: begin
                        if (ss_rise) begin
`ifdef SPI_VIEW_DOUBLE_BUFFER_EN
                            pend_reg    <= rx_view;
                            pending_reg <= 1'b1;
`else
                            out_reg     <= rx_view;
`endif
                            state_reg <= ST_IDLE;
                        end else if (sclk_rise) begin
                            // Extra bit past the payload: frame is too long.
                            frame_err_reg <= 1'b1;
                            cnt_reg       <= sat_inc(cnt_reg);
                            state_reg     <= ST_IGNORE;
                        end
                    end

                    ST_IGNORE: begin
                        if (ss_rise) begin
                            state_reg <= ST_IDLE;
                        end else if (sclk_rise) begin
                            cnt_reg <= sat_inc(cnt_reg);
                        end
                    end

                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign o_px        = out_reg[5];
    assign o_py        = out_reg[4];
    assign o_fx        = out_reg[3];
    assign o_fy        = out_reg[2];
    assign o_vx        = out_reg[1];
    assign o_vy        = out_reg[0];
    assign o_frame_err = frame_err_reg;

`ifdef SPI_VIEW_DOUBLE_BUFFER_EN
    assign o_pending = pending_reg;
`else
    assign o_pending = 1'b0;
`endif

endmodule

// File: tb/tb_spi_view_loader.sv
// ---------------------------------------------------------------------------
// tb_spi_view_loader
// Directed bench for spi_view_loader. Drives SPI frames at clk/8, keeps a
// scoreboard of expected output-set updates and compares it with the updates
// seen on the outputs. Expectations follow SPI_VIEW_DOUBLE_BUFFER_EN.
// ---------------------------------------------------------------------------
module tb_spi_view_loader;

`ifdef SPI_VIEW_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    localparam logic [95:0] RESET_VIEW = {16'h0180, 16'h0180, 16'h0100,
                                          16'h0000, 16'h0000, 16'hFF80};
    localparam logic [95:0] VIEW_A  = {16'h0300, 16'h0480, 16'h0000,
                                       16'h0100, 16'hFF80, 16'h0000};
    localparam logic [95:0] VIEW_B1 = {16'h0100, 16'h0111, 16'h0122,
                                       16'h0133, 16'h0144, 16'h0155};
    localparam logic [95:0] VIEW_B2 = {16'h0200, 16'h0211, 16'h0222,
                                       16'h0233, 16'h0244, 16'h0255};
    localparam logic [95:0] VIEW_P  = {16'h0700, 16'h0710, 16'hFF00,
                                       16'h0000, 16'h0000, 16'h0080};
    localparam logic [95:0] VIEW_Q  = {16'h0800, 16'h0810, 16'h0000,
                                       16'hFF00, 16'h0080, 16'h0000};
    localparam logic [95:0] VIEW_R  = {16'h1234, 16'h5678, 16'h9ABC,
                                       16'hDEF0, 16'h0F0F, 16'hF0F0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        ss_n = 1'b1;
    logic        vblank = 1'b0;
    logic [15:0] px, py, fx, fy, vx, vy;
    logic        pending;
    logic        frame_err;
    logic [95:0] view;

    always #5 clk = ~clk;

    spi_view_loader #(
        .W        (16),
        .CMD_VIEW (8'h00)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_sclk         (sclk),
        .i_mosi         (mosi),
        .i_ss_n         (ss_n),
        .i_vblank_start (vblank),
        .o_px           (px),
        .o_py           (py),
        .o_fx           (fx),
        .o_fy           (fy),
        .o_vx           (vx),
        .o_vy           (vy),
        .o_pending      (pending),
        .o_frame_err    (frame_err)
    );

    assign view = {px, py, fx, fy, vx, vy};

    // Scoreboard: exp_q filled by the stimulus, obs_q by the output monitor.
    logic [95:0] exp_q[$];
    logic [95:0] obs_q[$];
    logic [95:0] prev_view = RESET_VIEW;
    int          err_cnt = 0;
    int          err_wide = 0;
    logic        err_prev = 1'b0;
    int          n_total = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    always @(negedge clk) begin
        if (view !== prev_view) obs_q.push_back(view);
        prev_view <= view;
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
        if (frame_err === 1'b1 && err_prev === 1'b1) err_wide <= err_wide + 1;
        err_prev <= frame_err;
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [7:0] cmd, input logic [95:0] v);
        return {cmd, v, 24'h0};
    endfunction

    task automatic half_bit();
        repeat (4) @(negedge clk);
    endtask

    task automatic ss_begin();
        @(negedge clk);
        ss_n = 1'b0;
        half_bit();
    endtask

    task automatic shift_bits(input logic [127:0] f, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            mosi = f[127 - i];
            half_bit();
            sclk = 1'b1;
            half_bit();
            sclk = 1'b0;
        end
    endtask

    // Raise ss_n and sample o_pending one cycle before and at the cycle the
    // frame should be staged; optionally line vblank up with staging.
    task automatic ss_end(input bit vb_at_stage, output logic p_before, output logic p_at);
        half_bit();
        ss_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        p_before = pending;
        if (vb_at_stage) vblank = 1'b1;
        @(negedge clk);
        p_at = pending;
        vblank = 1'b0;
        half_bit();
    endtask

    task automatic send_frame(input logic [127:0] f, input int n, input bit vb_at_stage,
                              output logic p_before, output logic p_at);
        ss_begin();
        shift_bits(f, 0, n);
        ss_end(vb_at_stage, p_before, p_at);
    endtask

    task automatic pulse_vblank();
        @(negedge clk);
        vblank = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (12) @(negedge clk);
        #1;
        chk({tag, "_count"}, 96'(obs_q.size()), 96'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            chk(tag, obs_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        obs_q.delete();
        $display("step %s done", tag);
    endtask

    initial begin
        logic p1, p2;
        int   e0;

        // Reset state, checked before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_view", view, RESET_VIEW);
        chk("rst_pending", 96'(pending), 96'(0));
        chk("rst_err", 96'(frame_err), 96'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Valid frame.
        e0 = err_cnt;
        if (!DB) exp_q.push_back(VIEW_A);
        send_frame(mk(8'h00, VIEW_A), 104, 1'b0, p1, p2);
        chk("A_pend_before", 96'(p1), 96'(0));
        chk("A_pend_at", 96'(p2), 96'(DB));
        drain("A_stage");
        pulse_vblank();
        if (DB) exp_q.push_back(VIEW_A);
        drain("A_commit");
        chk("A_pend_after", 96'(pending), 96'(0));
        chk("A_err", 96'(err_cnt - e0), 96'(0));

        // Short frame: 50 payload bits.
        e0 = err_cnt;
        send_frame(mk(8'h00, VIEW_B1), 58, 1'b0, p1, p2);
        drain("short");
        chk("short_err", 96'(err_cnt - e0), 96'(1));
        chk("short_pend", 96'(p2), 96'(0));

        // Long frame: 105 bits.
        e0 = err_cnt;
        send_frame(mk(8'h00, VIEW_B2), 105, 1'b0, p1, p2);
        drain("long");
        chk("long_err", 96'(err_cnt - e0), 96'(1));
        chk("long_pend", 96'(p2), 96'(0));

        // Wrong command: drained without error.
        e0 = err_cnt;
        send_frame(mk(8'h5A, VIEW_P), 104, 1'b0, p1, p2);
        drain("wrong_cmd");
        chk("wrong_err", 96'(err_cnt - e0), 96'(0));
        chk("wrong_pend", 96'(p2), 96'(0));

        // Two valid frames before vblank: latest wins.
        if (!DB) begin
            exp_q.push_back(VIEW_B1);
            exp_q.push_back(VIEW_B2);
        end
        send_frame(mk(8'h00, VIEW_B1), 104, 1'b0, p1, p2);
        send_frame(mk(8'h00, VIEW_B2), 104, 1'b0, p1, p2);
        chk("ovw_pend", 96'(pending), 96'(DB));
        pulse_vblank();
        if (DB) exp_q.push_back(VIEW_B2);
        drain("overwrite");

        // Staging coincident with vblank.
        if (!DB) exp_q.push_back(VIEW_P);
        send_frame(mk(8'h00, VIEW_P), 104, 1'b0, p1, p2);
        drain("P_stage");
        if (DB) exp_q.push_back(VIEW_P);
        else exp_q.push_back(VIEW_Q);
        send_frame(mk(8'h00, VIEW_Q), 104, 1'b1, p1, p2);
        drain("coincide");
        chk("coincide_pend", 96'(pending), 96'(DB));
        pulse_vblank();
        if (DB) exp_q.push_back(VIEW_Q);
        drain("Q_commit");
        chk("Q_pend_after", 96'(pending), 96'(0));

        // Asynchronous reset in the middle of a frame; rest of frame ignored.
        e0 = err_cnt;
        ss_begin();
        shift_bits(mk(8'h00, VIEW_R), 0, 30);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_view", view, RESET_VIEW);
        chk("midrst_pend", 96'(pending), 96'(0));
        exp_q.push_back(RESET_VIEW);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        shift_bits(mk(8'h00, VIEW_R), 30, 74);
        ss_end(1'b0, p1, p2);
        drain("midrst");
        chk("midrst_err", 96'(err_cnt - e0), 96'(0));
        chk("midrst_pend_end", 96'(p2), 96'(0));

        // Recovery with a fresh frame.
        if (!DB) exp_q.push_back(VIEW_R);
        send_frame(mk(8'h00, VIEW_R), 104, 1'b0, p1, p2);
        pulse_vblank();
        if (DB) exp_q.push_back(VIEW_R);
        drain("recover");

        chk("err_width", 96'(err_wide), 96'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
